// File: rtl/ctrl_pkg.sv
// Shared encodings for the raster-pass controller: FSM state type and the
// mode values it drives into the address calculators, SRAM and window buffer.
package ctrl_pkg;

    localparam logic [2:0] WB_NOP  = 3'd0;
    localparam logic [2:0] WB_S1   = 3'd1;
    localparam logic [2:0] WB_S2   = 3'd2;
    localparam logic [2:0] WB_SD3  = 3'd3;
    localparam logic [2:0] WB_SD4  = 3'd4;
    localparam logic [2:0] WB_SHFT = 3'd5;

    localparam logic SRAM_READ  = 1'b1;
    localparam logic SRAM_WRITE = 1'b0;

    localparam logic AC_SRAM_ROWCACHE = 1'b1;
    localparam logic AC_SRAM_OUTARR   = 1'b0;

    localparam logic AC_SDRAM_READ  = 1'b1;
    localparam logic AC_SDRAM_WRITE = 1'b0;

    // Seventeen states, so the register is one bit wider than a nibble.
    typedef enum logic [4:0] {
        IDLE, FR_RD, FR_WAIT, FR_WR, FR_UPD, J_INC,
        C_RD, C_WAIT, C_WB3, S_RD, S_WAIT, C_WB1,
        C_SHFT, O_WR, O_UPD, C_UPD, DONE
    } state_t;

endpackage

// File: rtl/control_unit.sv
// Moore sequencer for one raster pass: row 0 fills the SRAM row cache, later
// rows feed the window buffer and write one result per column after the first.
module control_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_flag,
    input  logic       dataRead_sram,
    input  logic       dataRead_sdram,
    input  logic       rollover_i,
    input  logic       rollover_j,
    input  logic       rollover_i_wr,
    output logic       enable_i,
    output logic       enable_j,
    output logic       enable_i_wr,
    output logic       enable_addr_calc_sram,
    output logic       enable_addr_calc_sdram,
    output logic       enable_WB,
    output logic       enable_sram,
    output logic       read_en_sdram,
    output logic       write_en_sdram,
    output logic       mode_addr_calc_sram,
    output logic       mode_addr_calc_sdram,
    output logic [2:0] mode_WB,
    output logic       mode_sram,
    output logic       finish_flag
);

    state_t state, next_state;
    logic   first_col;

    // Output-column wrap is informational only; it never steers the sequence.
    logic unused_rollover_i_wr;
    assign unused_rollover_i_wr = rollover_i_wr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            first_col <= 1'b0;
        end else begin
            state <= next_state;
            if (state == J_INC)
                first_col <= 1'b1;
            else if (state == C_UPD)
                first_col <= 1'b0;
        end
    end

    // NOTE: next_state gets a default before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_flag) next_state = FR_RD;
            FR_RD:   next_state = dataRead_sdram ? FR_WR : FR_WAIT;
            FR_WAIT: if (dataRead_sdram) next_state = FR_WR;
            FR_WR:   next_state = FR_UPD;
            FR_UPD:  next_state = rollover_i ? J_INC : FR_RD;
            J_INC:   next_state = rollover_j ? DONE : C_RD;
            C_RD:    next_state = dataRead_sdram ? C_WB3 : C_WAIT;
            C_WAIT:  if (dataRead_sdram) next_state = C_WB3;
            C_WB3:   next_state = S_RD;
            S_RD:    next_state = S_WAIT;
            S_WAIT:  if (dataRead_sram) next_state = C_WB1;
            C_WB1:   next_state = first_col ? C_UPD : C_SHFT;
            C_SHFT:  next_state = O_WR;
            O_WR:    next_state = O_UPD;
            O_UPD:   next_state = C_UPD;
            C_UPD:   next_state = rollover_i ? J_INC : C_RD;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        enable_i               = 1'b0;
        enable_j               = 1'b0;
        enable_i_wr            = 1'b0;
        enable_addr_calc_sram  = 1'b0;
        enable_addr_calc_sdram = 1'b0;
        enable_WB              = 1'b0;
        enable_sram            = 1'b0;
        read_en_sdram          = 1'b0;
        write_en_sdram         = 1'b0;
        mode_addr_calc_sram    = AC_SRAM_ROWCACHE;
        mode_addr_calc_sdram   = AC_SDRAM_READ;
        mode_WB                = WB_NOP;
        mode_sram              = SRAM_WRITE;
        finish_flag            = 1'b0;
        case (state)
            FR_RD, C_RD: read_en_sdram = 1'b1;
            FR_WR: begin
                enable_sram         = 1'b1;
                mode_sram           = SRAM_WRITE;
                mode_addr_calc_sram = AC_SRAM_ROWCACHE;
            end
            FR_UPD, C_UPD: begin
                enable_i               = 1'b1;
                enable_addr_calc_sram  = 1'b1;
                enable_addr_calc_sdram = 1'b1;
            end
            J_INC: enable_j = 1'b1;
            C_WB3: begin
                enable_WB = 1'b1;
                mode_WB   = WB_SD3;
            end
            S_RD: begin
                enable_sram         = 1'b1;
                mode_sram           = SRAM_READ;
                mode_addr_calc_sram = AC_SRAM_ROWCACHE;
            end
            C_WB1: begin
                enable_WB = 1'b1;
                mode_WB   = WB_S1;
            end
            C_SHFT: begin
                enable_WB = 1'b1;
                mode_WB   = WB_SHFT;
            end
            O_WR: begin
                write_en_sdram       = 1'b1;
                mode_addr_calc_sdram = AC_SDRAM_WRITE;
            end
            O_UPD: begin
                enable_i_wr            = 1'b1;
                enable_addr_calc_sdram = 1'b1;
                mode_addr_calc_sdram   = AC_SDRAM_WRITE;
            end
            DONE:    finish_flag = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench: a raster-pass model predicts the strobe sequence
// while a responder plays memory latency and the i/j counters around the DUT.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start_flag;
    logic       dataRead_sram, dataRead_sdram;
    logic       rollover_i, rollover_j, rollover_i_wr;
    logic       enable_i, enable_j, enable_i_wr;
    logic       enable_addr_calc_sram, enable_addr_calc_sdram;
    logic       enable_WB, enable_sram, read_en_sdram, write_en_sdram;
    logic       mode_addr_calc_sram, mode_addr_calc_sdram;
    logic [2:0] mode_WB;
    logic       mode_sram, finish_flag;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .n_rst(n_rst), .start_flag(start_flag),
        .dataRead_sram(dataRead_sram), .dataRead_sdram(dataRead_sdram),
        .rollover_i(rollover_i), .rollover_j(rollover_j), .rollover_i_wr(rollover_i_wr),
        .enable_i(enable_i), .enable_j(enable_j), .enable_i_wr(enable_i_wr),
        .enable_addr_calc_sram(enable_addr_calc_sram),
        .enable_addr_calc_sdram(enable_addr_calc_sdram),
        .enable_WB(enable_WB), .enable_sram(enable_sram),
        .read_en_sdram(read_en_sdram), .write_en_sdram(write_en_sdram),
        .mode_addr_calc_sram(mode_addr_calc_sram), .mode_addr_calc_sdram(mode_addr_calc_sdram),
        .mode_WB(mode_WB), .mode_sram(mode_sram), .finish_flag(finish_flag)
    );

    // {9 strobes, ac_sram mode, ac_sdram mode, WB mode, sram mode, finish}
    logic [15:0] out_vec;
    assign out_vec = {enable_i, enable_j, enable_i_wr, enable_addr_calc_sram,
                      enable_addr_calc_sdram, enable_WB, enable_sram, read_en_sdram,
                      write_en_sdram, mode_addr_calc_sram, mode_addr_calc_sdram,
                      mode_WB, mode_sram, finish_flag};

    function automatic logic [15:0] mk(input logic [8:0] s, input logic ms, input logic md,
                                       input logic [2:0] wb, input logic sr, input logic fn);
        return {s, ms, md, wb, sr, fn};
    endfunction

    // Strobe order: en_i, en_j, en_i_wr, ac_sram, ac_sdram, WB, sram, rd, wr
    logic [15:0] DEF, E_RD, E_CWR, E_UPD, E_J, E_WB3, E_SRD, E_WB1, E_SH, E_OWR, E_OUPD, E_DONE;
    initial begin
        DEF    = mk(9'b000000000, 1, 1, 3'd0, 0, 0);
        E_RD   = mk(9'b000000010, 1, 1, 3'd0, 0, 0);
        E_CWR  = mk(9'b000000100, 1, 1, 3'd0, 0, 0);
        E_UPD  = mk(9'b100110000, 1, 1, 3'd0, 0, 0);
        E_J    = mk(9'b010000000, 1, 1, 3'd0, 0, 0);
        E_WB3  = mk(9'b000001000, 1, 1, 3'd3, 0, 0);
        E_SRD  = mk(9'b000000100, 1, 1, 3'd0, 1, 0);
        E_WB1  = mk(9'b000001000, 1, 1, 3'd1, 0, 0);
        E_SH   = mk(9'b000001000, 1, 1, 3'd5, 0, 0);
        E_OWR  = mk(9'b000000001, 1, 0, 3'd0, 0, 0);
        E_OUPD = mk(9'b001010000, 1, 0, 3'd0, 0, 0);
        E_DONE = mk(9'b000000000, 1, 1, 3'd0, 0, 1);
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];
    int w_cfg = 1;
    int h_cfg = 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Expected strobe stream for one pass over a w x h image.
    task automatic build_pass(input int w, input int h);
        for (int c = 0; c < w; c++) begin
            exp_q.push_back(E_RD);
            exp_q.push_back(E_CWR);
            exp_q.push_back(E_UPD);
        end
        exp_q.push_back(E_J);
        for (int r = 1; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                exp_q.push_back(E_RD);
                exp_q.push_back(E_WB3);
                exp_q.push_back(E_SRD);
                exp_q.push_back(E_WB1);
                if (c > 0) begin
                    exp_q.push_back(E_SH);
                    exp_q.push_back(E_OWR);
                    exp_q.push_back(E_OUPD);
                end
                exp_q.push_back(E_UPD);
            end
            exp_q.push_back(E_J);
        end
        exp_q.push_back(E_DONE);
    endtask

    // Monitor plus memory/counter responder, all at the falling edge.
    initial begin : monitor
        int i_cnt = 0, j_cnt = 0, sd_cnt = 0, sr_cnt = 0;
        bit sd_pend = 0, sr_pend = 0;
        logic [15:0] e;
        rollover_i = 0; rollover_j = 0; rollover_i_wr = 0;
        dataRead_sdram = 0; dataRead_sram = 0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                check("reset_outputs", out_vec, DEF);
                i_cnt = 0; j_cnt = 0; sd_pend = 0; sr_pend = 0;
                dataRead_sdram = 0; dataRead_sram = 0;
                rollover_i = 0; rollover_j = 0;
            end else begin
                if (out_vec[15:7] != 9'd0 || out_vec[0]) begin
                    if (exp_q.size() == 0) check("unexpected_event", out_vec, DEF);
                    else begin
                        e = exp_q.pop_front();
                        check("event", out_vec, e);
                    end
                end else begin
                    check("idle_defaults", out_vec, DEF);
                end
                rollover_i = (i_cnt == w_cfg - 1);
                rollover_j = (j_cnt == h_cfg - 1);
                if (enable_i) i_cnt = (i_cnt == w_cfg - 1) ? 0 : i_cnt + 1;
                if (enable_j) j_cnt++;
                if (finish_flag) begin i_cnt = 0; j_cnt = 0; end
                rollover_i_wr = 1'($urandom % 2);
                dataRead_sdram = 0;
                dataRead_sram  = 0;
                if (read_en_sdram) begin sd_pend = 1; sd_cnt = $urandom_range(0, 3); end
                if (enable_sram && mode_sram) begin sr_pend = 1; sr_cnt = $urandom_range(1, 3); end
                if (sd_pend) begin
                    if (sd_cnt == 0) begin dataRead_sdram = 1; sd_pend = 0; end
                    else sd_cnt--;
                end
                if (sr_pend) begin
                    if (sr_cnt == 0) begin dataRead_sram = 1; sr_pend = 0; end
                    else sr_cnt--;
                end
            end
        end
    end

    task automatic run_pass(input int w, input int h);
        w_cfg = w; h_cfg = h;
        build_pass(w, h);
        @(negedge clk);
        start_flag = 1;
        @(negedge clk);
        for (int k = 0; k < 3000 && exp_q.size() != 0; k++) begin
            start_flag = (exp_q.size() > 4) ? 1'($urandom % 2) : 1'b0;
            @(negedge clk);
        end
        start_flag = 0;
        check("pass_drained", 16'(exp_q.size()), 16'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin : main
        n_rst = 0;
        start_flag = 0;
        repeat (2) @(negedge clk);
        n_rst = 1;
        repeat (2) @(negedge clk);
        run_pass(2, 2);
        run_pass(1, 1);
        run_pass(4, 1);
        run_pass(1, 3);
        for (int p = 0; p < 8; p++)
            run_pass($urandom_range(1, 4), $urandom_range(1, 4));

        // Abort mid-pass: asynchronous reset must clear outputs at once.
        w_cfg = 3; h_cfg = 3;
        build_pass(3, 3);
        @(negedge clk);
        start_flag = 1;
        @(negedge clk);
        start_flag = 0;
        repeat ($urandom_range(5, 40)) @(negedge clk);
        #2 n_rst = 0;
        #1 check("async_reset", out_vec, DEF);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        n_rst = 1;
        repeat (2) @(negedge clk);
        run_pass(3, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
